// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator: combinational format decode feeding a
// 2-entry output FIFO with valid/ready handshakes on both sides.
module imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter int BJ_ADJ = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_src,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_ext,
  output logic            imm_err
);

  typedef enum logic [2:0] {
    FMT_I     = 3'b000,
    FMT_S     = 3'b001,
    FMT_B     = 3'b010,
    FMT_J     = 3'b011,
    FMT_U     = 3'b100,
    FMT_SHAMT = 3'b101,
    FMT_ZIMM  = 3'b110,
    FMT_ILL   = 3'b111
  } fmt_e;

  localparam logic [XLEN-1:0] ADJ = XLEN'(BJ_ADJ);

  logic [XLEN-1:0] imm_d;
  logic            err_d;

  // Opcode bits carry no immediate information in any format.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  // A size cast of a signed operand sign-extends, which gives sext() at XLEN.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    imm_d = '0;
    err_d = 1'b0;
    unique case (fmt_e'(imm_src))
      FMT_I:     imm_d = XLEN'($signed(instr[31:20]));
      FMT_S:     imm_d = XLEN'($signed({instr[31:25], instr[11:7]}));
      FMT_B:     imm_d = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                        instr[11:8], 1'b0})) - ADJ;
      FMT_J:     imm_d = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                        instr[30:21], 1'b0})) - ADJ;
      FMT_U:     imm_d = XLEN'($signed({instr[31:12], 12'b0}));
      FMT_SHAMT: imm_d = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
      FMT_ZIMM:  imm_d = XLEN'(instr[19:15]);
      FMT_ILL:   err_d = 1'b1;
      default:   err_d = 1'b1;
    endcase
  end

  logic [XLEN-1:0] imm_mem [2];
  logic            err_mem [2];
  logic            head;
  logic            tail;
  logic [1:0]      count;
  logic            push;
  logic            pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Masked while empty so the consumer never sees stale entries.
  assign imm_ext = out_valid ? imm_mem[head] : '0;
  assign imm_err = out_valid ? err_mem[head] : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is cleared too; it is only two entries and it keeps
      // simulation free of X on the masked read path.
      imm_mem[0] <= '0;
      imm_mem[1] <= '0;
      err_mem[0] <= 1'b0;
      err_mem[1] <= 1'b0;
      head       <= 1'b0;
      tail       <= 1'b0;
      count      <= 2'd0;
    end else if (flush) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments let every register sample pre-edge
      // values, so head/tail/count updates here are order-independent.
      if (push) begin
        imm_mem[tail] <= imm_d;
        err_mem[tail] <= err_d;
        tail          <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 32-bit BJ_ADJ=4 instance and a 64-bit
// BJ_ADJ=0 instance share one stimulus stream.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  imm_src;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, imm_err_a;
  logic [31:0] imm_ext_a;
  logic        in_ready_b, out_valid_b, imm_err_b;
  logic [63:0] imm_ext_b;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .BJ_ADJ(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a),
    .instr(instr), .imm_src(imm_src),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .imm_ext(imm_ext_a), .imm_err(imm_err_a)
  );

  imm_gen_pipe #(.XLEN(64), .BJ_ADJ(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .instr(instr), .imm_src(imm_src),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .imm_ext(imm_ext_b), .imm_err(imm_err_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one entry for exactly one edge, then withdraw it.
  task automatic push_one(input logic [31:0] word, input logic [2:0] src);
    in_valid = 1'b1;
    instr    = word;
    imm_src  = src;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [63:0] exp_a,
                            input logic [63:0] exp_b, input logic exp_err);
    check({tag, "_valid_a"}, 64'(out_valid_a), 64'd1);
    check({tag, "_imm_a"},   64'(imm_ext_a),   exp_a);
    check({tag, "_err_a"},   64'(imm_err_a),   64'(exp_err));
    check({tag, "_imm_b"},   imm_ext_b,        exp_b);
    check({tag, "_err_b"},   64'(imm_err_b),   64'(exp_err));
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    instr     = '0;
    imm_src   = '0;
    out_ready = 1'b1;
    #2;
    check("rst_valid",  64'(out_valid_a), 64'd0);
    check("rst_ready",  64'(in_ready_a),  64'd1);
    check("rst_imm",    64'(imm_ext_a),   64'd0);
    check("rst_err",    64'(imm_err_a),   64'd0);
    check("rst_valid_b", 64'(out_valid_b), 64'd0);
    #10 rst_n = 1'b1;
    tick();

    // Format decode, one entry at a time with the consumer always ready.
    push_one(32'hFFF0_0093, 3'b000);
    check_head("i_type", 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    push_one(32'hFE00_0E23, 3'b001);
    check_head("s_type", 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    push_one(32'h0000_0463, 3'b010);
    check_head("b_type", 64'h0000_0004, 64'h0000_0000_0000_0008, 1'b0);
    push_one(32'h0000_006F, 3'b011);
    check_head("j_zero", 64'hFFFF_FFFC, 64'h0, 1'b0);
    push_one(32'h8000_00B7, 3'b100);
    check_head("u_type", 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0);
    push_one(32'h03F0_9093, 3'b101);
    check_head("shamt", 64'h1F, 64'h3F, 1'b0);
    push_one(32'h0007_D073, 3'b110);
    check_head("zimm", 64'h0F, 64'h0F, 1'b0);
    push_one(32'hFFFF_FFFF, 3'b111);
    check_head("illegal", 64'h0, 64'h0, 1'b1);
    tick();
    check("drain_valid", 64'(out_valid_a), 64'd0);
    check("drain_mask",  64'(imm_ext_a),   64'd0);
    check("drain_err",   64'(imm_err_a),   64'd0);

    // Backpressure: third entry must be held off by in_ready.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    imm_src   = 3'b000;
    instr     = 32'h0010_0093;
    tick();
    check("bp_ready_c1", 64'(in_ready_a), 64'd1);
    instr = 32'h0020_0093;
    tick();
    check("bp_ready_c2", 64'(in_ready_a), 64'd0);
    instr = 32'h0030_0093;
    tick();
    check("bp_ready_held", 64'(in_ready_a), 64'd0);
    check("bp_head1",      64'(imm_ext_a),  64'd1);
    out_ready = 1'b1;
    tick();
    check("bp_head2",      64'(imm_ext_a),  64'd2);
    check("bp_ready_c1b",  64'(in_ready_a), 64'd1);
    tick();
    check("pushpop_valid", 64'(out_valid_a), 64'd1);
    check("pushpop_head3", 64'(imm_ext_a),   64'd3);
    check("pushpop_ready", 64'(in_ready_a),  64'd1);
    in_valid = 1'b0;
    tick();
    check("bp_empty", 64'(out_valid_a), 64'd0);

    // Flush at count 2 with a pending push.
    out_ready = 1'b0;
    push_one(32'h0050_0093, 3'b000);
    push_one(32'h0060_0093, 3'b000);
    flush    = 1'b1;
    in_valid = 1'b1;
    instr    = 32'h0070_0093;
    #1;
    check("flush_ready_during", 64'(in_ready_a), 64'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush2_valid", 64'(out_valid_a), 64'd0);
    check("flush2_ready", 64'(in_ready_a),  64'd1);

    // Flush at count 1 while push and pop are both possible: push is dropped.
    push_one(32'h0080_0093, 3'b000);
    check("pre_flush1_head", 64'(imm_ext_a), 64'd8);
    out_ready = 1'b1;
    flush     = 1'b1;
    in_valid  = 1'b1;
    instr     = 32'h0090_0093;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush1_valid", 64'(out_valid_a), 64'd0);
    tick();
    check("flush1_still_empty", 64'(out_valid_a), 64'd0);

    // Asynchronous reset mid-cycle with an illegal entry at the head.
    out_ready = 1'b0;
    push_one(32'h1234_5678, 3'b111);
    check("prerst_err", 64'(imm_err_a), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid_a), 64'd0);
    check("arst_imm",   64'(imm_ext_a),   64'd0);
    check("arst_err",   64'(imm_err_a),   64'd0);
    check("arst_ready", 64'(in_ready_a),  64'd1);
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_ready", 64'(in_ready_a),  64'd1);
    check("post_rst_valid", 64'(out_valid_a), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
